// File: rtl/pipe_arb_pkg.sv
// Shared types and helpers for the pipelined round-robin arbiter.
// Holds the lock FSM state encoding (used when PIPE_ARB_LOCK_EN is defined),
// the reset pointer value and a clog2 helper that never returns zero.
package pipe_arb_pkg;

  // Arbitration FSM: ARB_ST arbitrates per beat, LOCK_ST holds a multi-beat packet owner
  typedef enum logic {
    ARB_ST  = 1'b0,
    LOCK_ST = 1'b1
  } arb_st_e;

  // Pointer value after reset: requester 0 holds highest priority
  localparam int PTR_RST = 0;

  // Index width for n requesters; at least one bit so NREQ=1 still has a port
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pipe_rr_arbiter_rr_pick.sv
// Rotate-priority encoder: first set request at or after ptr, wrapping at NREQ-1.
// Latency: purely combinational.
// Backpressure: none; the caller qualifies the result with its own load condition.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic            found,
  output logic [IDW-1:0]  idx
);

  int cand;

  // Scan offsets from the far end back to ptr so the nearest-to-ptr request is written last and wins
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = int'(ptr) + k;
      if (cand >= NREQ) begin
        cand = cand - NREQ;
      end
      if (req[cand]) begin
        found = 1'b1;
        idx   = IDW'(cand);
      end
    end
  end

endmodule

// File: rtl/pipe_rr_arbiter.sv
// Round-robin arbiter feeding one registered valid/ready output stage; optional packet lock via PIPE_ARB_LOCK_EN.
// Latency: one cycle from accepted request to DataOutVld; 1 beat/cycle when DataOutRdy is held high.
// Backpressure: ReqRdy is combinational on DataOutRdy; while the output stalls all ReqRdy are 0 and DataOut holds.
import pipe_arb_pkg::*;

module pipe_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 8,
  parameter int IDW  = clog2_min1(NREQ)
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic [NREQ*DW-1:0]   ReqDataIn,
  input  logic [NREQ-1:0]      ReqVld,
  output logic [NREQ-1:0]      ReqRdy,
  output logic [DW-1:0]        DataOut,
  output logic                 DataOutVld,
  input  logic                 DataOutRdy,
`ifdef PIPE_ARB_LOCK_EN
  input  logic [NREQ-1:0]      ReqLast,
`endif
  output logic [IDW-1:0]       GrantId
);

  logic [DW-1:0]   data_q, data_d;
  logic            vld_q,  vld_d;
  logic [IDW-1:0]  gid_q,  gid_d;
  logic [IDW-1:0]  ptr_q,  ptr_d;

  logic            load;
  logic            found;
  logic            xfer;
  logic            adv_ptr;
  logic [IDW-1:0]  win;
  logic [IDW-1:0]  ptr_nxt;
  logic [NREQ-1:0] pick_req;

`ifdef PIPE_ARB_LOCK_EN
  arb_st_e         st_q;
  logic [IDW-1:0]  lock_q;

  // While locked only the packet owner is visible to the picker
  always_comb begin
    pick_req = '0;
    for (int i = 0; i < NREQ; i++) begin
      pick_req[i] = ReqVld[i] && ((st_q != LOCK_ST) || (IDW'(i) == lock_q));
    end
  end

  // Pointer only moves once the packet's last beat is taken
  assign adv_ptr = xfer && ReqLast[win];

  // Lock FSM: enter on a non-last beat, leave on the owner's last beat
  always_ff @(posedge Clk) begin
    if (Rst) begin
      st_q   <= ARB_ST;
      lock_q <= '0;
    end else begin
      case (st_q)
        ARB_ST: begin
          if (xfer && !ReqLast[win]) begin
            st_q   <= LOCK_ST;
            lock_q <= win;
          end
        end
        LOCK_ST: begin
          if (xfer && ReqLast[win]) begin
            st_q <= ARB_ST;
          end
        end
        default: st_q <= ARB_ST;
      endcase
    end
  end
`else
  assign pick_req = ReqVld;
  assign adv_ptr  = xfer;
`endif

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req   (pick_req),
    .ptr   (ptr_q),
    .found (found),
    .idx   (win)
  );

  // Output register may accept a new beat when empty or being drained this cycle
  assign load = !vld_q || DataOutRdy;
  assign xfer = load && found && !Rst;

  // Explicit wrap: for non-power-of-two NREQ, win+1 would land on a nonexistent requester
  assign ptr_nxt = (int'(win) == NREQ - 1) ? '0 : win + IDW'(1);

  // One-hot ready to the winner only, and only when the beat will actually be taken
  always_comb begin
    ReqRdy = '0;
    if (xfer) begin
      ReqRdy[win] = 1'b1;
    end
  end

  // Next state of the output stage and pointer; everything holds during a stall
  always_comb begin
    data_d = data_q;
    vld_d  = vld_q;
    gid_d  = gid_q;
    ptr_d  = ptr_q;
    if (xfer) begin
      data_d = ReqDataIn[int'(win)*DW +: DW];
      gid_d  = win;
      vld_d  = 1'b1;
      if (adv_ptr) begin
        ptr_d = ptr_nxt;
      end
    end else if (load) begin
      vld_d = 1'b0;
    end
  end

  // Output stage and pointer registers; reset drops any held beat
  always_ff @(posedge Clk) begin
    if (Rst) begin
      data_q <= '0;
      vld_q  <= 1'b0;
      gid_q  <= '0;
      ptr_q  <= IDW'(PTR_RST);
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
      gid_q  <= gid_d;
      ptr_q  <= ptr_d;
    end
  end

  assign DataOut    = data_q;
  assign DataOutVld = vld_q;
  assign GrantId    = gid_q;

endmodule

// File: tb/tb_pipe_rr_arbiter.sv
// Testbench for pipe_rr_arbiter: directed steps then randomized traffic against a reference model.
// Inputs change 1 time unit after the rising edge; outputs are checked 2 units later.
// ReqLast is tied high when PIPE_ARB_LOCK_EN is defined, so every beat is a single-beat packet.
module tb_pipe_rr_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int IDW  = 2;

  logic                 Clk = 1'b0;
  logic                 Rst;
  logic [NREQ*DW-1:0]   ReqDataIn;
  logic [NREQ-1:0]      ReqVld;
  logic [NREQ-1:0]      ReqRdy;
  logic [DW-1:0]        DataOut;
  logic                 DataOutVld;
  logic                 DataOutRdy;
  logic [IDW-1:0]       GrantId;
`ifdef PIPE_ARB_LOCK_EN
  logic [NREQ-1:0]      ReqLast;
  assign ReqLast = '1;
`endif

  pipe_rr_arbiter #(.NREQ(NREQ), .DW(DW)) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .ReqDataIn  (ReqDataIn),
    .ReqVld     (ReqVld),
    .ReqRdy     (ReqRdy),
    .DataOut    (DataOut),
    .DataOutVld (DataOutVld),
    .DataOutRdy (DataOutRdy),
`ifdef PIPE_ARB_LOCK_EN
    .ReqLast    (ReqLast),
`endif
    .GrantId    (GrantId)
  );

  always #5 Clk = ~Clk;

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic [DW-1:0] din [NREQ];
  bit            m_vld;
  int            m_dat;
  int            m_gid;
  int            m_ptr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // First valid requester at or after p going round the ring, -1 if none
  function automatic int pick(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic pack_data();
    for (int i = 0; i < NREQ; i++) ReqDataIn[i*DW +: DW] = din[i];
  endtask

  // Check outputs for the current inputs, clock once, advance the model
  task automatic step();
    int w;
    bit ld;
    logic [NREQ-1:0] er;
    #2;
    w  = pick(ReqVld, m_ptr);
    ld = !m_vld || DataOutRdy;
    er = '0;
    if (!Rst && ld && w >= 0) er[w] = 1'b1;
    chk("out_vld", 32'(DataOutVld), 32'(m_vld));
    chk("out_dat", 32'(DataOut), 32'(m_dat));
    chk("grant_id", 32'(GrantId), 32'(m_gid));
    chk("req_rdy", 32'(ReqRdy), 32'(er));
    @(posedge Clk);
    if (Rst) begin
      m_vld = 1'b0; m_dat = 0; m_gid = 0; m_ptr = 0;
    end else if (ld && w >= 0) begin
      m_dat = int'(din[w]); m_gid = w; m_vld = 1'b1; m_ptr = (w + 1) % NREQ;
    end else if (ld) begin
      m_vld = 1'b0;
    end
    #1;
  endtask

  initial begin
    m_vld = 1'b0; m_dat = 0; m_gid = 0; m_ptr = 0;
    Rst = 1'b1;
    ReqVld = '1;
    DataOutRdy = 1'b1;
    for (int i = 0; i < NREQ; i++) din[i] = 8'hA0 + 8'(i);
    pack_data();
    @(posedge Clk);
    #1;

    // Reset held with all requesters valid: nothing granted
    step();
    step();

    // Round robin from requester 0
    Rst = 1'b0;
    step();
    chk("first_dat", 32'(DataOut), 32'h A0);
    chk("first_gid", 32'(GrantId), 32'd0);
    step();
    chk("second_dat", 32'(DataOut), 32'h A1);

    // Stall on A1 for three cycles
    DataOutRdy = 1'b0;
    step(); step(); step();
    chk("stall_dat", 32'(DataOut), 32'h A1);
    chk("stall_gid", 32'(GrantId), 32'd1);
    DataOutRdy = 1'b1;
    step();
    chk("post_stall_gid", 32'(GrantId), 32'd2);

    // Bring pointer to 2, then sparse requesters 1 and 3
    ReqVld = 4'b0010;
    step();
    ReqVld = 4'b1010;
    step();
    chk("sparse_gid3", 32'(GrantId), 32'd3);
    chk("sparse_dat3", 32'(DataOut), 32'h A3);
    step();
    chk("sparse_wrap_gid1", 32'(GrantId), 32'd1);

    // Reset while a beat is stalled: beat dropped, pointer back to 0
    DataOutRdy = 1'b0;
    ReqVld = '1;
    step();
    Rst = 1'b1;
    step();
    chk("midrst_vld", 32'(DataOutVld), 32'd0);
    Rst = 1'b0;
    DataOutRdy = 1'b1;
    step();
    chk("midrst_gid", 32'(GrantId), 32'd0);
    chk("midrst_dat", 32'(DataOut), 32'h A0);

    // Randomized traffic with occasional reset
    for (int n = 0; n < 400; n++) begin
      ReqVld = NREQ'($urandom);
      DataOutRdy = ($urandom_range(0, 3) != 0);
      Rst = ($urandom_range(0, 49) == 0);
      for (int i = 0; i < NREQ; i++) din[i] = 8'($urandom);
      pack_data();
      step();
    end
    Rst = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
